// File: rtl/subtractor_pipe.sv
// Pipelined N-bit subtractor D = A - B - borrow_in with valid/ready flow control.
// One N/STAGES-bit chunk of the borrow chain is resolved per stage, LSB chunk first.
module subtractor_pipe #(
    parameter int N      = 64,
    parameter int STAGES = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_borrow_in,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_d,
    output logic         o_borrow_out,
    output logic         o_overflow,
    output logic         o_zero
);

    localparam int W = N / STAGES;

    logic adv;

    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // Operand bits still unprocessed when entering stage k
        localparam int RW = N - k * W;

        logic [RW-1:0]        a_in;
        logic [RW-1:0]        nb_in;
        logic                 v_in;
        logic                 b_in;
        logic                 z_in;
        logic                 am_in;
        logic                 bm_in;
        logic [W:0]           sum;
        logic [(k+1)*W-1:0]   d_d;
        logic                 valid_q;
        logic [(k+1)*W-1:0]   d_q;
        logic                 bor_q;
        logic                 zero_q;
        logic                 am_q;
        logic                 bm_q;

        if (k == 0) begin : g_src
            assign a_in  = i_a;
            assign nb_in = ~i_b;
            assign v_in  = i_valid;
            assign b_in  = i_borrow_in;
            assign z_in  = 1'b1;
            assign am_in = i_a[N-1];
            assign bm_in = i_b[N-1];
            assign d_d   = sum[W-1:0];
        end else begin : g_src
            assign a_in  = g_st[k-1].g_rem.a_q;
            assign nb_in = g_st[k-1].g_rem.nb_q;
            assign v_in  = g_st[k-1].valid_q;
            assign b_in  = g_st[k-1].bor_q;
            assign z_in  = g_st[k-1].zero_q;
            assign am_in = g_st[k-1].am_q;
            assign bm_in = g_st[k-1].bm_q;
            assign d_d   = {sum[W-1:0], g_st[k-1].d_q};
        end

        // Carry in is the inverted borrow; carry out inverts back to borrow
        assign sum = {1'b0, a_in[W-1:0]} + {1'b0, nb_in[W-1:0]}
                   + {{W{1'b0}}, ~b_in};

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                valid_q <= 1'b0;
                d_q     <= '0;
                bor_q   <= 1'b0;
                zero_q  <= 1'b0;
                am_q    <= 1'b0;
                bm_q    <= 1'b0;
            end else if (adv) begin
                valid_q <= v_in;
                if (v_in) begin
                    d_q    <= d_d;
                    bor_q  <= ~sum[W];
                    zero_q <= z_in && (sum[W-1:0] == '0);
                    am_q   <= am_in;
                    bm_q   <= bm_in;
                end
            end
        end

        if (k < STAGES - 1) begin : g_rem
            logic [RW-W-1:0] a_q;
            logic [RW-W-1:0] nb_q;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    a_q  <= '0;
                    nb_q <= '0;
                end else if (adv && v_in) begin
                    a_q  <= a_in[RW-1:W];
                    nb_q <= nb_in[RW-1:W];
                end
            end
        end
    end

    assign o_valid      = g_st[STAGES-1].valid_q;
    assign o_d          = g_st[STAGES-1].d_q;
    assign o_borrow_out = g_st[STAGES-1].bor_q;
    assign o_zero       = g_st[STAGES-1].zero_q;
    assign o_overflow   = (g_st[STAGES-1].am_q ^ g_st[STAGES-1].bm_q)
                        && (o_d[N-1] ^ g_st[STAGES-1].am_q);

endmodule

// File: tb/tb_subtractor_pipe.sv
// Directed and streaming bench for subtractor_pipe (N=64, STAGES=4).
module tb_subtractor_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_a;
    logic [63:0] i_b;
    logic        i_borrow_in;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_d;
    logic        o_borrow_out;
    logic        o_overflow;
    logic        o_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    subtractor_pipe #(.N(64), .STAGES(4)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_borrow_in (i_borrow_in),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_d         (o_d),
        .o_borrow_out(o_borrow_out),
        .o_overflow  (o_overflow),
        .o_zero      (o_zero)
    );

    function automatic logic [66:0] model(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic bin);
        logic [64:0] t;
        logic [63:0] d;
        t = {1'b0, a} - {1'b0, b} - {64'd0, bin};
        d = t[63:0];
        return {d, t[64], (a[63] != b[63]) && (d[63] != a[63]), d == 64'd0};
    endfunction

    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic bin, output logic [66:0] res,
                          output int lat);
        @(negedge clk);
        i_a = a;
        i_b = b;
        i_borrow_in = bin;
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = {o_d, o_borrow_out, o_overflow, o_zero};
    endtask

    task automatic test_reset;
        logic [66:0] o;
        rst = 1'b1;
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_a = 64'd5;
        i_b = 64'd3;
        i_borrow_in = 1'b0;
        repeat (3) @(negedge clk);
        o = {o_d, o_borrow_out, o_overflow, o_zero};
        checks++;
        if (o !== 67'd0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%h v=%b exp=0 v=0", o, o_valid);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", o_ready);
        end
        i_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset got v=%b r=%b exp v=0 r=1", o_valid, o_ready);
        end
    endtask

    task automatic test_basic;
        logic [66:0] r;
        int lat;
        run_op(64'd5, 64'd3, 1'b0, r, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=4", lat);
        end
        checks++;
        if (r !== {64'd2, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL basic_5m3 got=%h exp=%h", r, {64'd2, 3'b000});
        end
    endtask

    task automatic test_underflow;
        logic [66:0] r;
        int lat;
        run_op(64'd0, 64'd1, 1'b0, r, lat);
        checks++;
        if (r !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL underflow_0m1 got=%h exp=%h", r,
                     {64'hFFFF_FFFF_FFFF_FFFF, 3'b100});
        end
        run_op(64'h10, 64'h0F, 1'b1, r, lat);
        checks++;
        if (r !== {64'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL zero_borrowin got=%h exp=%h", r, {64'd0, 3'b001});
        end
    endtask

    task automatic test_overflow;
        logic [66:0] r;
        int lat;
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, r, lat);
        checks++;
        if (r !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL ovf_min_m1 got=%h exp=%h", r,
                     {64'h7FFF_FFFF_FFFF_FFFF, 3'b010});
        end
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, r, lat);
        checks++;
        if (r !== {64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL ovf_max_mneg1 got=%h exp=%h", r,
                     {64'h8000_0000_0000_0000, 3'b110});
        end
    endtask

    task automatic test_cross_chunk;
        logic [66:0] r;
        int lat;
        run_op(64'h0000_0001_0000_0000, 64'd1, 1'b0, r, lat);
        checks++;
        if (r !== {64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL cross_chunk got=%h exp=%h", r,
                     {64'h0000_0000_FFFF_FFFF, 3'b000});
        end
    endtask

    task automatic test_stream(input bit stall);
        logic [63:0] va [8];
        logic [63:0] vb [8];
        logic        vc [8];
        logic [66:0] q[$];
        logic [66:0] snap;
        logic [66:0] cur;
        logic [66:0] exp_r;
        int idx = 0;
        int got = 0;
        int first = -1;
        int last = -1;
        for (int i = 0; i < 8; i++) begin
            va[i] = {$urandom(), $urandom()};
            vb[i] = {$urandom(), $urandom()};
            vc[i] = 1'($urandom_range(0, 1));
        end
        for (int it = 0; it < 40 && got < 8; it++) begin
            @(negedge clk);
            i_ready = !(stall && it >= 5 && it <= 7);
            if (idx < 8) begin
                i_valid = 1'b1;
                i_a = va[idx];
                i_b = vb[idx];
                i_borrow_in = vc[idx];
            end else begin
                i_valid = 1'b0;
            end
            #1;
            cur = {o_d, o_borrow_out, o_overflow, o_zero};
            if (stall && it == 5) begin
                snap = cur;
                checks++;
                if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_ready got v=%b r=%b exp v=1 r=0",
                             o_valid, o_ready);
                end
            end
            if (stall && it >= 6 && it <= 8) begin
                checks++;
                if (cur !== snap || o_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_stable it=%0d got=%h exp=%h", it, cur, snap);
                end
            end
            if (o_valid && i_ready) begin
                exp_r = (q.size() > 0) ? q.pop_front() : 67'h0;
                checks++;
                if (cur !== exp_r) begin
                    failures++;
                    $display("FAIL stream_result s=%0d n=%0d got=%h exp=%h",
                             stall, got, cur, exp_r);
                end
                if (first < 0) first = it;
                last = it;
                got++;
            end
            if (i_valid && o_ready) begin
                q.push_back(model(va[idx], vb[idx], vc[idx]));
                idx++;
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
        checks++;
        if (got !== 8 || q.size() !== 0) begin
            failures++;
            $display("FAIL stream_count s=%0d got=%0d left=%0d exp=8,0",
                     stall, got, q.size());
        end
        if (!stall) begin
            checks++;
            if (first !== 4 || last - first !== 7) begin
                failures++;
                $display("FAIL stream_timing first=%0d span=%0d exp=4,7",
                         first, last - first);
            end
        end
    endtask

    task automatic test_reset_midflight;
        logic [66:0] r;
        int lat;
        int stale = 0;
        i_ready = 1'b1;
        for (int it = 0; it < 3; it++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_a = (it == 0) ? 64'h8000_0000_0000_0000 : 64'd0;
            i_b = 64'd1;
            i_borrow_in = 1'b0;
        end
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_d !== 64'h7FFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL pre_reset got v=%b d=%h exp v=1 d=7fffffffffffffff",
                     o_valid, o_d);
        end
        #1 rst = 1'b1;
        #1;
        r = {o_d, o_borrow_out, o_overflow, o_zero};
        checks++;
        if (o_valid !== 1'b0 || r !== 67'd0 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got v=%b out=%h r=%b exp v=0 out=0 r=1",
                     o_valid, r, o_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (o_valid) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL stale_after_reset got=%0d exp=0", stale);
        end
        run_op(64'd20, 64'd7, 1'b0, r, lat);
        checks++;
        if (lat !== 4 || r !== {64'd13, 3'b000}) begin
            failures++;
            $display("FAIL after_reset_op lat=%0d got=%h exp lat=4 %h",
                     lat, r, {64'd13, 3'b000});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_overflow();
        test_cross_chunk();
        test_stream(1'b0);
        test_stream(1'b1);
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/subtractor_pipe.md
# subtractor_pipe

Pipelined N-bit subtractor with a valid/ready handshake. It computes D = A − B − borrow_in and reports the borrow-out, signed overflow and zero flags. It is the inverse-direction companion to the combinational carry-lookahead adder in the datapath. The borrow chain is split across STAGES register stages, so long operands close timing at full clock rate with a throughput of one operation per cycle.

## Interface
- N, 64: operand and result width; must be a multiple of STAGES.
- STAGES, 4: number of pipeline stages; each stage resolves one N/STAGES-bit chunk, LSB chunk first; STAGES ≥ 1.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_valid  in  1  input operands are valid this cycle.
- o_ready  out  1  block can accept an operand pair this cycle.
- i_a  in  N  minuend, unsigned or two's complement.
- i_b  in  N  subtrahend.
- i_borrow_in  in  1  borrow into bit 0.
- o_valid  out  1  result outputs are valid.
- i_ready  in  1  downstream accepts the result this cycle.
- o_d  out  N  difference, (A − B − borrow_in) mod 2^N.
- o_borrow_out  out  1  1 iff A < B + borrow_in (unsigned).
- o_overflow  out  1  signed overflow: (A[N-1] ≠ B[N-1]) && (D[N-1] ≠ A[N-1]).
- o_zero  out  1  1 iff o_d == 0.

## Operation
- Arithmetic: each chunk computes A_chunk + ~B_chunk + carry, where the carry into chunk 0 = ~i_borrow_in and borrow = ~carry. Result width is exactly N; there is no sign extension.
- Stage k (1..STAGES) registers:
  - its valid bit;
  - the resolved low k chunks of D;
  - the chunk carry;
  - the unprocessed high chunks of A and ~B;
  - A[N-1] and B[N-1], for the overflow computation.
- Stage 1 processes chunk 0 combinationally from the inputs.
- Global advance: adv = !o_valid || i_ready, and o_ready = adv (combinational).
  - When adv = 1, every stage loads from its predecessor. Stage 1 loads i_valid && o_ready.
  - When adv = 0, all stages hold. Bubbles are not collapsed while stalled.
- Accept: the transfer fires on an edge where i_valid && o_ready. The producer must hold operands while i_valid && !o_ready.
- Output: o_d, o_borrow_out, o_overflow and o_zero are driven from the last stage's registers. They are computed registered or combinationally from last-stage state and are never taken from the inputs.
- When o_valid = 0 the data outputs hold their last value and carry no meaning.
- Ordering: strictly FIFO; results leave in acceptance order.
- Reset, including mid-operation: all valid bits clear immediately (asynchronously) and in-flight operations are discarded. All outputs go to 0: o_valid = 0, o_d = 0, flags = 0. o_ready = 1 while in reset and after release.
- No state machine beyond the per-stage valid bits; the pipeline is the controller.

## Timing
- Latency: for an operation accepted on edge E, o_valid = 1 after edge E+STAGES−1 (STAGES=4: after edge E+3). With STAGES=1 the result is valid after the accepting edge itself.
- Throughput: one accept per cycle while i_ready = 1 continuously.
- Stall: when o_valid && !i_ready, the pipeline freezes. o_ready = 0 in the same cycle. Outputs stay bit-stable until the edge where i_ready = 1.
- Simultaneous events: an output consumed and an input accepted on the same edge are both legal; no cycle is lost.
- Full: all STAGES valid with i_ready = 0 means o_ready = 0, and nothing is lost or duplicated.
- Empty: o_valid = 0 and o_ready = 1.
- Wrap-around: results are modulo 2^N. The borrow flags an underflow; D is never saturated.

## Test plan
- Reset then 5 − 3, borrow_in 0: after 4 edges o_valid = 1, o_d = 2, borrow 0, overflow 0, zero 0. Outputs were all 0 during reset.
- Underflow, 0 − 1, borrow_in 0: o_d = 64'hFFFFFFFFFFFFFFFF, borrow 1, overflow 0. Then 64'h10 − 64'h0F with borrow_in 1: o_d = 0, zero 1, borrow 0.
- Signed overflow, 64'h8000000000000000 − 1: o_d = 64'h7FFFFFFFFFFFFFFF, overflow 1, borrow 0. 64'h7FFFFFFFFFFFFFFF − 64'hFFFFFFFFFFFFFFFF: o_d = 64'h8000000000000000, overflow 1, borrow 1.
- Cross-chunk borrow, 64'h0000000100000000 − 1: o_d = 64'h00000000FFFFFFFF; the borrow ripples through chunks 0 and 1.
- Streaming with stall:
  - Send 8 back-to-back random pairs with i_ready = 1. Results appear on consecutive cycles in order and match a reference model.
  - Repeat with i_ready held 0 for 3 cycles mid-stream. o_ready drops in the same cycle as the stall, outputs are stable throughout, and no result is lost or duplicated.
- Reset mid-flight: accept 3 operations, assert i_reset between edges. o_valid and outputs drop to 0 immediately, no stale result emerges after release, and the next accepted operation returns correctly after 4 edges.
